// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver (and the future
// transmitter): FSM state encoding, parity mode encodings, bit-timing
// derivation and the parity check rule.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per bit on the line.
  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Cycles from the start edge to the middle of the start bit.
  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt(clk_freq, baud) / 2;
  endfunction

  // data_xor is the XOR of all payload bits, par_bit the received parity bit.
  function automatic logic parity_error(input int mode, input logic data_xor,
                                        input logic par_bit);
    logic ones_odd;
    ones_odd = data_xor ^ par_bit;
    case (mode)
      PARITY_ODD:  return ~ones_odd;
      PARITY_EVEN: return ones_odd;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: a 3-flop chain ff0 -> ff1 -> ff2
// that brings the asynchronous pin into the clk domain, plus falling-edge
// detection used as the start condition.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (chain resets to idle-high)
//   rx_uart    asynchronous serial input
//   rx_s       synchronised line (ff1), used for every line sample
//   start_edge ff1 = 0 && ff2 = 1
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_uart,
  output logic rx_s,
  output logic start_edge
);

  // ff_q[0] = ff0, ff_q[1] = ff1, ff_q[2] = ff2
  logic [2:0] ff_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge clk) begin
    if (rst) ff_q <= 3'b111;
    else     ff_q <= {ff_q[1:0], rx_uart};
  end

  assign rx_s       = ff_q[1];
  assign start_edge = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start-bit glitch rejection, optional parity,
// one or two stop bits, and a valid/ready output register with overrun flag.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   rx_uart     asynchronous serial input, idle high
//   rx_data     received payload (LSB first on the line), valid with rx_valid
//   rx_valid    payload available, held until rx_valid && rx_ready
//   rx_ready    consumer accept
//   parity_err  payload parity mismatch (always 0 without parity)
//   frame_err   a stop bit was sampled 0
//   overrun     1-cycle pulse: a frame completed while the register was full
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic start_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_uart   (rx_uart),
    .rx_s      (rx_s),
    .start_edge(start_edge)
  );

  // ---------------- receive FSM ----------------
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;      // parity result of the frame in flight
  logic                 ferr_q;      // first stop bit was 0 (two-stop frames)
  logic                 stop_idx_q;  // which stop bit is being sampled

  logic bit_tick;
  logic last_stop;
  logic frame_done;
  logic frame_ferr;

  assign bit_tick   = (cnt_q == BIT_LAST);
  assign last_stop  = (STOP_BITS == 1) || stop_idx_q;
  assign frame_done = (state_q == ST_STOP) && bit_tick && last_stop;
  assign frame_ferr = ferr_q | ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start_edge) state_q <= ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            // Line high again at mid-start-bit: glitch, not a frame.
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              ferr_q     <= 1'b0;
              stop_idx_q <= 1'b0;
              state_q    <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            perr_q  <= parity_error(PARITY, ^shift_q, rx_s);
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            // Leave at mid-stop-bit so an immediately following start edge is seen.
            if (last_stop) begin
              state_q <= ST_IDLE;
            end else begin
              ferr_q     <= ~rx_s;
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------- output register ----------------
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (frame_done) begin
      // Register is free (or being emptied this cycle): load the new frame.
      if (!valid_q || rx_ready) begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        perr_out_d = perr_q;
        ferr_out_d = frame_ferr;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers with different frame formats
// (8N1, 8E1, 7O2) at 16 clocks per bit. Directed table, hand-written corner
// sequences, and random frames checked against a frame-level scoreboard.
module tb_uart_rx_param;

  localparam int BIT = 16;
  localparam int DB  [3] = '{8, 8, 7};
  localparam int PAR [3] = '{0, 2, 1};
  localparam int SB  [3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line  [3];
  logic rx_ready [3];
  logic v  [3];
  logic pe [3];
  logic fe [3];
  logic ov [3];
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx_uart(rx_line[0]), .rx_data(d0), .rx_valid(v[0]),
    .rx_ready(rx_ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .rx_uart(rx_line[1]), .rx_data(d1), .rx_valid(v[1]),
    .rx_ready(rx_ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .rx_uart(rx_line[2]), .rx_data(d2), .rx_valid(v[2]),
    .rx_ready(rx_ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));

  typedef struct {
    int         inst;
    logic [8:0] data;
    bit         par_flip;   // send the wrong parity bit
    logic [1:0] stops;      // stops[s] = value driven for stop bit s
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
    string      name;
  } vec_t;

  typedef struct {
    logic [8:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  function automatic logic [8:0] dat(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b00, d2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic val, input int n);
    rx_line[idx] = val;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full frame as seen on the pin: start, payload LSB first, parity, stops, short idle.
  task automatic send_frame(input int idx, input logic [8:0] data, input bit par_flip,
                            input logic [1:0] stops);
    int ones;
    logic p;
    drive(idx, 1'b0, BIT);
    ones = 0;
    for (int b = 0; b < DB[idx]; b++) begin
      drive(idx, data[b], BIT);
      ones += int'(data[b]);
    end
    if (PAR[idx] != 0) begin
      // Even: parity bit makes the total count of ones even; odd: odd.
      p = (PAR[idx] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
      drive(idx, p ^ logic'(par_flip), BIT);
    end
    for (int s = 0; s < SB[idx]; s++) drive(idx, stops[s], BIT);
    drive(idx, 1'b1, 4);
  endtask

  task automatic expect_frame(input int idx, input logic [8:0] ed, input bit ep,
                              input bit ef, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (v[idx] === 1'b1) seen = 1'b1;
    end
    check({name, "_valid"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_data"}, 32'(dat(idx)), 32'(ed));
      check({name, "_perr"}, 32'(pe[idx]), 32'(ep));
      check({name, "_ferr"}, 32'(fe[idx]), 32'(ef));
      if (rx_ready[idx] === 1'b1) begin
        @(negedge clk);
        check({name, "_valid_1cyc"}, 32'(v[idx]), 32'd0);
      end
    end
  endtask

  task automatic rand_tx(input int idx, input int n);
    exp_t       e;
    logic [8:0] data;
    bit         flip;
    logic [1:0] stops;
    for (int k = 0; k < n; k++) begin
      data  = 9'($urandom_range(0, (1 << DB[idx]) - 1));
      flip  = (PAR[idx] != 0) && ($urandom_range(0, 3) == 0);
      stops = 2'b11;
      if ($urandom_range(0, 3) == 0) stops[$urandom_range(0, SB[idx] - 1)] = 1'b0;
      e.data = data;
      e.perr = flip;
      e.ferr = 1'b0;
      for (int s = 0; s < SB[idx]; s++) if (!stops[s]) e.ferr = 1'b1;
      case (idx)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
      send_frame(idx, data, flip, stops);
      drive(idx, 1'b1, $urandom_range(0, 20));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ov[i] === 1'b1) ovr_cnt[i]++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [10];
  bit   rand_done;

  initial begin
    int   base, cnt;
    exp_t e;
    bit   have;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, "t1_8n1_a5"};
    vecs[1] = '{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0, "t2_even_p1"};
    vecs[2] = '{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0, "t2_even_p0"};
    vecs[3] = '{0, 9'h05A, 1'b0, 2'b10, 9'h05A, 1'b0, 1'b1, "t3_stop0"};
    vecs[4] = '{2, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b0, 1'b1, "t3_2nd_stop0"};
    vecs[5] = '{2, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b1, 1'b0, "odd_badpar"};
    vecs[6] = '{2, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0, "odd_zero"};
    vecs[7] = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0, "even_ff"};
    vecs[8] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0, "8n1_00"};
    vecs[9] = '{0, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b1, "8n1_ff_stop0"};

    for (int i = 0; i < 3; i++) begin
      rx_line[i]  = 1'b1;
      rx_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_valid%0d", i), 32'(v[i]), 32'd0);
      check($sformatf("reset_data%0d", i), 32'(dat(i)), 32'd0);
      check($sformatf("reset_errs%0d", i), {30'd0, pe[i], fe[i]}, 32'd0);
      check($sformatf("reset_ovr%0d", i), 32'(ov[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) rx_ready[i] = 1'b1;
    drive(0, 1'b1, 10);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      fork
        send_frame(vecs[i].inst, vecs[i].data, vecs[i].par_flip, vecs[i].stops);
        expect_frame(vecs[i].inst, vecs[i].exp_data, vecs[i].exp_perr,
                     vecs[i].exp_ferr, vecs[i].name);
      join
      drive(vecs[i].inst, 1'b1, 8);
    end

    // Start-bit glitch shorter than half a bit, then a real frame
    drive(0, 1'b0, 5);
    rx_line[0] = 1'b1;
    cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (v[0] === 1'b1) cnt++;
    end
    check("t4_glitch_no_valid", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    fork
      send_frame(0, 9'h03C, 1'b0, 2'b11);
      expect_frame(0, 9'h03C, 1'b0, 1'b0, "t4_after_glitch");
    join

    // Overrun: consumer stalled across two frames
    rx_ready[0] = 1'b0;
    base = ovr_cnt[0];
    fork
      send_frame(0, 9'h011, 1'b0, 2'b11);
      expect_frame(0, 9'h011, 1'b0, 1'b0, "t5_first");
    join
    send_frame(0, 9'h022, 1'b0, 2'b11);
    drive(0, 1'b1, 4);
    check("t5_data_held", 32'(dat(0)), 32'h11);
    check("t5_valid_held", 32'(v[0]), 32'd1);
    check("t5_overrun_pulses", 32'(ovr_cnt[0] - base), 32'd1);
    rx_ready[0] = 1'b1;
    @(negedge clk);
    check("t5_valid_at_accept", 32'(v[0]), 32'd1);
    @(negedge clk);
    check("t5_valid_falls", 32'(v[0]), 32'd0);
    @(posedge clk); #1;

    // Reset mid-frame, with an unaccepted payload pending
    rx_ready[0] = 1'b0;
    fork
      send_frame(0, 9'h077, 1'b0, 2'b11);
      expect_frame(0, 9'h077, 1'b0, 1'b0, "t6_pending");
    join
    drive(0, 1'b0, BIT);
    for (int b = 0; b < 4; b++) drive(0, 1'b1, BIT);
    drive(0, 1'b0, BIT / 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rx_line[0] = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(v[0]), 32'd0);
    check("t6_rst_data", 32'(dat(0)), 32'd0);
    check("t6_rst_errs", {30'd0, pe[0], fe[0]}, 32'd0);
    rx_ready[0] = 1'b1;
    cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (v[0] === 1'b1) cnt++;
    end
    check("t6_abandoned_no_valid", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    fork
      send_frame(0, 9'h0C3, 1'b0, 2'b11);
      expect_frame(0, 9'h0C3, 1'b0, 1'b0, "t6_after_rst");
    join

    // Random frames on all three receivers, random consumer back-pressure
    drive(0, 1'b1, 10);
    base = ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2];
    rand_done = 1'b0;
    fork
      begin
        fork
          rand_tx(0, 12);
          rand_tx(1, 12);
          rand_tx(2, 12);
        join
        repeat (40) @(posedge clk);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          for (int i = 0; i < 3; i++) rx_ready[i] = 1'($urandom_range(0, 1));
        end
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          for (int i = 0; i < 3; i++) begin
            if (v[i] === 1'b1 && rx_ready[i] === 1'b1) begin
              have = 1'b0;
              if (i == 0 && q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
              if (i == 1 && q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
              if (i == 2 && q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
              check($sformatf("rand%0d_expected", i), 32'(have), 32'd1);
              if (have) begin
                check($sformatf("rand%0d_data", i), 32'(dat(i)), 32'(e.data));
                check($sformatf("rand%0d_perr", i), 32'(pe[i]), 32'(e.perr));
                check($sformatf("rand%0d_ferr", i), 32'(fe[i]), 32'(e.ferr));
              end
            end
          end
        end
      end
    join
    check("rand_q0_drained", 32'(q0.size()), 32'd0);
    check("rand_q1_drained", 32'(q1.size()), 32'd0);
    check("rand_q2_drained", 32'(q2.size()), 32'd0);
    check("rand_no_overrun", 32'(ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2] - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
